acc_uart_tx: RTL and testbench
==============================

# acc_uart_tx

Downstream observer stage for the 6-bit CPU. It watches the accumulator output (`acc_out`) and pushes every changed value into a small FIFO. It then serialises each queued value as an 8N1 UART frame on a single `tx` pin, so accumulator traces can be logged off-chip without stalling the CPU. The block never back-pressures the CPU: when the FIFO is full, new values are dropped and flagged.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range ≥ 2.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.
- `WIDTH`, default 6: accumulator width; must be ≤ 8.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `acc_in`, input, `WIDTH`: accumulator value from the CPU (`acc_out`).
- `tx`, output, 1: UART serial line; idles high.
- `busy`, output, 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `overflow`, output, 1: sticky; set when a value is dropped; cleared only by reset.
- `fifo_count`, output, $clog_2(DEPTH)+1: number of queued entries.

## Operation

- **Change detector.**
  - Register `prev_acc` resets to 0 and loads `acc_in` on every edge.
  - A push is requested on an edge where `acc_in != prev_acc`.
  - An `acc_in` of 0 straight after reset generates no push.
- **FIFO.**
  - Circular buffer with separate read and write pointers that wrap modulo `DEPTH`, plus a count register.
  - A push while `count == DEPTH` with no pop that edge: value discarded, `overflow` set to 1, pointers unchanged.
  - A push and a pop on the same edge are both accepted, including when full; count is unchanged.
- **Frame format.**
  - 1 start bit (0).
  - 8 data bits, LSB first; the byte is `acc_in` zero-extended to 8 bits.
  - 1 stop bit (1).
  - Each bit is held for exactly `CLKS_PER_BIT` cycles.
- **FSM.** States are IDLE, START, DATA, STOP.
  - IDLE → START: on an edge where count (registered value) ≠ 0. On that edge, pop the head into an 8-bit shift register, clear the bit timer, and drive `tx` to 0.
  - START → DATA: after `CLKS_PER_BIT` cycles. Bit index resets to 0 and `tx` = shift[0].
  - DATA: every `CLKS_PER_BIT` cycles, shift right and increment the index. After index 7 has been held for its full period, go to STOP with `tx` = 1.
  - STOP → IDLE: after `CLKS_PER_BIT` cycles.
  - `tx` is registered and changes only on bit boundaries.
- **Reset.**
  - Asynchronous assertion, mid-frame included, immediately forces: `tx` = 1, `busy` = 0, `overflow` = 0, `fifo_count` = 0, FSM to IDLE, pointers and `prev_acc` to 0.
  - Any partial frame is abandoned, not completed.
  - Deassertion is taken synchronously at the next edge.

## Timing

- **Reset values:** `tx` = 1, `busy` = 0, `overflow` = 0, `fifo_count` = 0.
- **Push latency:** an `acc_in` change sampled at edge E0 gives `fifo_count` incremented after E0.
- **Pop latency:** with the FSM idle, pop occurs at E1 and `tx` falls after E1. This gives 2 edges from change to start bit.
- **Frame duration:** exactly 10 × `CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** at least 1 IDLE cycle (`tx` = 1) between consecutive frames, because the pop happens on the edge after STOP exits.
- **`busy`:** combinational from state and count; it drops on the same edge that the FSM enters IDLE with an empty FIFO.
- **Multiple changes:** changes on consecutive cycles are each captured, one per edge. No coalescing.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 and `DEPTH` = 4.

1. **Reset values.** Hold `rst_n` = 0, then release with `acc_in` = 0 for 50 cycles → `tx` stays 1; `busy`, `overflow` and `fifo_count` stay 0; no frame.
2. **Single frame.** Change `acc_in` from 0 to 5 → after 2 edges, `tx` shows the bit sequence 0, 1,0,1,0,0,0,0,0, 1. Each bit is 4 cycles, 40 cycles total. `busy` then drops and `tx` returns to 1.
3. **Steady input.** Hold `acc_in` = 5 for 100 cycles after scenario 2 → no further frames.
4. **Overflow.** Drive `acc_in` = 1,2,3,4,5,6 on six consecutive edges, then hold. Expected:
   - value 1 is popped at once; `fifo_count` peaks at 4;
   - value 6 is dropped and `overflow` = 1;
   - exactly 5 frames are sent, carrying 1,2,3,4,5 in order;
   - `overflow` stays 1 afterwards.
5. **Glitch capture.** Drive `acc_in` 3 → 7 → 3 on consecutive edges, from idle with `prev_acc` = 3 → two frames are sent, carrying 7 then 3.
6. **Reset mid-frame.** Assert `rst_n` = 0 during the DATA bit 3 of a frame with 2 entries queued. Expected:
   - `tx` = 1 asynchronously, before the next edge;
   - `fifo_count` = 0;
   - after release with `acc_in` = 0, no frame is sent;
   - a later change to 9 produces one correct frame.

Source files
------------

// File: rtl/acc_uart_tx.sv
// Accumulator trace observer: queues every change of acc_in in a small FIFO and
// transmits each queued value as an 8N1 UART frame on tx.
module acc_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4,
    parameter int WIDTH        = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         acc_in,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMAX     = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_acc_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [7:0]        mem [DEPTH];

    logic push, pop, full, wr_en, bit_done;

    assign push     = (acc_in != prev_acc_q);
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    // When full, a simultaneous pop frees the head slot, so the write is still taken.
    assign wr_en    = push && (!full || pop);
    assign bit_done = (timer_q == TMAX);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & full & ~pop);
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= 8'(acc_in);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_acc_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_acc_q <= acc_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic: tx only changes on bit boundaries
    always_comb begin
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    timer_d = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) timer_d = '0;
                else          timer_d = timer_q + 1'b1;
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_acc_uart_tx.sv
// Directed bench for acc_uart_tx (CLKS_PER_BIT=4, DEPTH=4); a monitor captures
// every 40-cycle frame on tx so scenarios can compare whole waveforms.
module tb_acc_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] acc_in;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;

    logic [39:0] frames_q[$];
    int          mon_cnt = 0;
    logic [39:0] mon_cap;

    acc_uart_tx #(.CLKS_PER_BIT(4), .DEPTH(4), .WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_in     (acc_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] exp_wave(input logic [7:0] d);
        logic [9:0]  fb;
        logic [39:0] w;
        fb = {1'b1, d, 1'b0};
        for (int k = 0; k < 40; k++) w[k] = fb[k/4];
        return w;
    endfunction

    task automatic check_frame(input int idx, input logic [7:0] d);
        logic [39:0] got;
        got = (idx < frames_q.size()) ? frames_q[idx] : 40'h0;
        check($sformatf("frame%0d_%02h", idx, d), 64'(got), 64'(exp_wave(d)));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            if (!busy) break;
            tick();
        end
        check(tag, 64'(busy), 64'd0);
        tick();
        tick();
    endtask

    // Frame monitor: one sample per cycle, 40 samples per frame.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mon_cnt = 0;
        end else if (mon_cnt == 0) begin
            if (tx == 1'b0) begin
                mon_cap    = '0;
                mon_cnt    = 1;
            end
        end else begin
            mon_cap[mon_cnt] = tx;
            mon_cnt++;
            if (mon_cnt == 40) begin
                logic [7:0] d;
                for (int k = 0; k < 8; k++) d[k] = mon_cap[4 + 4*k];
                frames_q.push_back(mon_cap);
                $display("tb: frame captured data=%02h", d);
                mon_cnt = 0;
            end
        end
    end

    initial begin
        logic        saw_bad;
        logic [2:0]  exp_cnt [6];
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

        // 1. Reset values and quiet idle
        rst_n  = 1'b0;
        acc_in = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        rst_n = 1'b1;
        saw_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || fifo_count !== 3'd0)
                saw_bad = 1'b1;
        end
        check("s1_idle_quiet", 64'(saw_bad), 64'd0);
        check("s1_no_frame", 64'(frames_q.size()), 64'd0);

        // 2. Single frame, value 5
        acc_in = 6'd5;
        tick();
        check("s2_push_count", 64'(fifo_count), 64'd1);
        check("s2_tx_before_pop", 64'(tx), 64'd1);
        tick();
        check("s2_start_tx", 64'(tx), 64'd0);
        check("s2_pop_count", 64'(fifo_count), 64'd0);
        check("s2_busy", 64'(busy), 64'd1);
        repeat (39) tick();
        check("s2_busy_stop", 64'(busy), 64'd1);
        tick();
        check("s2_busy_end", 64'(busy), 64'd0);
        check("s2_tx_end", 64'(tx), 64'd1);
        check("s2_nframes", 64'(frames_q.size()), 64'd1);
        check_frame(0, 8'h05);

        // 3. Steady input produces nothing
        frames_q.delete();
        saw_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) saw_bad = 1'b1;
        end
        check("s3_steady_quiet", 64'(saw_bad), 64'd0);
        check("s3_no_frame", 64'(frames_q.size()), 64'd0);

        // 4. Overflow: 1..6 on consecutive edges, 6 dropped
        for (int i = 0; i < 6; i++) begin
            acc_in = 6'(i + 1);
            tick();
            check($sformatf("s4_count_e%0d", i), 64'(fifo_count), 64'(exp_cnt[i]));
            if (i == 4) check("s4_overflow_before", 64'(overflow), 64'd0);
        end
        check("s4_overflow_set", 64'(overflow), 64'd1);
        wait_idle(400, "s4_idle");
        check("s4_nframes", 64'(frames_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) check_frame(i, 8'(i + 1));
        check("s4_overflow_sticky", 64'(overflow), 64'd1);

        // 5. Glitch capture 3 -> 7 -> 3
        acc_in = 6'd3;
        tick();
        wait_idle(100, "s5_setup_idle");
        frames_q.delete();
        acc_in = 6'd7;
        tick();
        acc_in = 6'd3;
        tick();
        wait_idle(200, "s5_idle");
        check("s5_nframes", 64'(frames_q.size()), 64'd2);
        check_frame(0, 8'h07);
        check_frame(1, 8'h03);

        // 6. Reset during DATA bit 3 with two entries queued
        acc_in = 6'd20;
        tick();
        acc_in = 6'd21;
        tick();
        acc_in = 6'd22;
        tick();
        check("s6_queued", 64'(fifo_count), 64'd2);
        repeat (15) tick();
        check("s6_bit3_tx", 64'(tx), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_tx", 64'(tx), 64'd1);
        check("s6_async_count", 64'(fifo_count), 64'd0);
        check("s6_async_busy", 64'(busy), 64'd0);
        check("s6_async_overflow", 64'(overflow), 64'd0);
        acc_in = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        frames_q.delete();
        saw_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) saw_bad = 1'b1;
        end
        check("s6_post_quiet", 64'(saw_bad), 64'd0);
        check("s6_post_no_frame", 64'(frames_q.size()), 64'd0);
        acc_in = 6'd9;
        tick();
        wait_idle(100, "s6_idle");
        check("s6_nframes", 64'(frames_q.size()), 64'd1);
        check_frame(0, 8'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
